// File: rtl/rt_elapsed_counter_pkg.sv
// Shared reaction-timer definitions: FSM state encoding and the 1 ms tick default.
// The countdown controller imports this same package.
package rt_elapsed_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HELD = 2'd2,
        ST_OVF  = 2'd3
    } state_t;

    localparam int TICK_DIV_1MS = 50000;
    localparam int BCD_W        = 4;

    function automatic logic is_nine(input logic [BCD_W-1:0] d);
        return d == 4'd9;
    endfunction

endpackage

// File: rtl/rt_elapsed_counter_bcd_digit.sv
// One packed-BCD digit: increments 0..9 and wraps, carry out when an increment wraps it.
module rt_elapsed_counter_bcd_digit
    import rt_elapsed_counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = is_nine(q_q) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & is_nine(q_q);

endmodule

// File: rtl/rt_elapsed_counter.sv
// Up-counting BCD elapsed-time counter: measures ticks from start to stop, saturating at all-9s.
module rt_elapsed_counter
    import rt_elapsed_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = TICK_DIV_1MS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  overflow
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;

    logic              tick;
    logic              go;
    logic              all_nines;
    logic              count_inc;
    logic              digit_clr;
    logic [DIGITS-1:0] inc_chain;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] nine;
    logic              carry_unused;

    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    // start from any non-RUN state re-arms from zero, unless stop is also present
    assign go        = start & ~stop & (state_q != ST_RUN);
    assign all_nines = &nine;
    assign count_inc = tick & ~stop & ~clear & ~all_nines;
    assign digit_clr = clear | go;

    assign inc_chain[0] = count_inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        rt_elapsed_counter_bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (digit_clr),
            .inc   (inc_chain[g]),
            .q     (count[4*g +: 4]),
            .carry (carry[g])
        );
        assign nine[g] = is_nine(count[4*g +: 4]);
        if (g < DIGITS - 1) begin : g_link
            assign inc_chain[g+1] = carry[g];
        end
    end

    // The top digit never wraps: saturation is caught before it could.
    assign carry_unused = carry[DIGITS-1];

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_HELD;
                        done_d  = 1'b1;
                    end else if (tick && all_nines) begin
                        state_d = ST_OVF;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    if (go) state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        presc_d = '0;
        if (!clear && state_q == ST_RUN && state_d == ST_RUN && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign running  = (state_q == ST_RUN);
    assign overflow = (state_q == ST_OVF);
    assign done     = done_q;

endmodule

// File: tb/tb_rt_elapsed_counter.sv
// Self-checking bench for rt_elapsed_counter (DIGITS=4, TICK_DIV=4).
module tb_rt_elapsed_counter;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int CMAX     = 9999;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HELD = 2;
    localparam int M_OVF  = 3;

    logic                clk;
    logic                reset, clear, start, stop;
    logic [4*DIGITS-1:0] count;
    logic                running, done, overflow;

    int checks = 0;
    int errors = 0;

    // reference model: elapsed value held as a plain integer
    int m_st, m_cnt, m_ph;
    bit m_done;

    rt_elapsed_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .running  (running),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          r, c, s, p;
        logic [15:0] e_count;
        bit          e_run, e_done, e_ovf;
    } vec_t;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] res;
        int          x;
        res = '0;
        x   = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return res;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        m_done = 1'b0;
        if (reset || clear) begin
            m_st = M_IDLE; m_cnt = 0; m_ph = 0;
        end else if (m_st == M_RUN) begin
            if (stop) begin
                m_st = M_HELD; m_done = 1'b1; m_ph = 0;
            end else if (m_ph == TICK_DIV - 1) begin
                m_ph = 0;
                if (m_cnt == CMAX) begin
                    m_st = M_OVF; m_done = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_ph++;
            end
        end else if (start && !stop) begin
            m_st = M_RUN; m_cnt = 0; m_ph = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit s, input bit p);
        reset = r; clear = c; start = s; stop = p;
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
        chk("model_count", count, to_bcd(m_cnt));
        chk("model_running", running, m_st == M_RUN);
        chk("model_done", done, m_done);
        chk("model_overflow", overflow, m_st == M_OVF);
        chk("digits_le9", bcd_ok(count), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    vec_t vecs[16];

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0;
        m_st = M_IDLE; m_cnt = 0; m_ph = 0; m_done = 1'b0;

        // reset, idle stop, start/stop together, tick timing, stop discarding a tick, clear
        vecs[0]  = '{1,0,0,0, 16'h0000, 0,0,0};
        vecs[1]  = '{1,0,0,0, 16'h0000, 0,0,0};
        vecs[2]  = '{0,0,0,1, 16'h0000, 0,0,0};
        vecs[3]  = '{0,0,1,1, 16'h0000, 0,0,0};
        vecs[4]  = '{0,0,1,0, 16'h0000, 1,0,0};
        vecs[5]  = '{0,0,0,0, 16'h0000, 1,0,0};
        vecs[6]  = '{0,0,0,0, 16'h0000, 1,0,0};
        vecs[7]  = '{0,0,0,0, 16'h0000, 1,0,0};
        vecs[8]  = '{0,0,0,0, 16'h0001, 1,0,0};
        vecs[9]  = '{0,0,1,0, 16'h0001, 1,0,0};
        vecs[10] = '{0,0,0,0, 16'h0001, 1,0,0};
        vecs[11] = '{0,0,0,0, 16'h0001, 1,0,0};
        vecs[12] = '{0,0,0,1, 16'h0001, 0,1,0};
        vecs[13] = '{0,0,0,0, 16'h0001, 0,0,0};
        vecs[14] = '{0,0,0,1, 16'h0001, 0,0,0};
        vecs[15] = '{0,1,0,0, 16'h0000, 0,0,0};

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].r, vecs[i].c, vecs[i].s, vecs[i].p);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d_running", i), running, vecs[i].e_run);
            chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
        end

        // measure 37 ticks, then hold
        cyc(0, 0, 1, 0);
        idle(4 * 37);
        cyc(0, 0, 0, 1);
        chk("t2_count", count, 16'h0037);
        chk("t2_done", done, 1);
        chk("t2_running", running, 0);
        cyc(0, 0, 0, 0);
        chk("t2_done_drop", done, 0);
        idle(99);
        chk("t2_hold", count, 16'h0037);

        // digit carries and saturation
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        for (int n = 1; n <= 4 * (CMAX + 1); n++) begin
            cyc(0, 0, 0, 0);
            if (n == 36)    chk("t3_0009", count, 16'h0009);
            if (n == 40)    chk("t3_0010", count, 16'h0010);
            if (n == 396)   chk("t3_0099", count, 16'h0099);
            if (n == 400)   chk("t3_0100", count, 16'h0100);
            if (n == 3996)  chk("t3_0999", count, 16'h0999);
            if (n == 4000)  chk("t3_1000", count, 16'h1000);
            if (n == 39996) chk("t4_9999_running", {count, 3'(running), 1'b0}, {16'h9999, 3'd1, 1'b0});
        end
        chk("t4_ovf", overflow, 1);
        chk("t4_ovf_done", done, 1);
        chk("t4_ovf_count", count, 16'h9999);
        idle(6);
        chk("t4_ovf_hold", count, 16'h9999);
        cyc(0, 0, 0, 1);
        chk("t4_ovf_stop_ignored", overflow, 1);
        cyc(0, 0, 1, 0);
        chk("t4_restart_count", count, 16'h0000);
        chk("t4_restart_ovf", overflow, 0);
        chk("t4_restart_running", running, 1);

        // start+stop together while running at 0005
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        idle(20);
        chk("t5_pre", count, 16'h0005);
        cyc(0, 0, 1, 1);
        chk("t5_count", count, 16'h0005);
        chk("t5_running", running, 0);
        chk("t5_done", done, 1);

        // reset mid-run, clear in HELD, re-arm from HELD
        cyc(0, 0, 1, 0);
        idle(4 * 123);
        chk("t6_0123", count, 16'h0123);
        cyc(1, 0, 0, 0);
        chk("t6_reset_count", count, 16'h0000);
        chk("t6_reset_running", running, 0);
        cyc(0, 0, 1, 0);
        idle(8);
        cyc(0, 0, 0, 1);
        chk("t6_held", count, 16'h0002);
        cyc(0, 1, 0, 0);
        chk("t6_clear_count", count, 16'h0000);
        chk("t6_clear_running", running, 0);
        cyc(0, 0, 1, 0);
        idle(12);
        cyc(0, 0, 0, 1);
        chk("t6_held2", count, 16'h0003);
        cyc(0, 0, 1, 0);
        chk("t6_rearm_count", count, 16'h0000);
        chk("t6_rearm_running", running, 1);

        // randomized control traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int rr;
            rr = int'($urandom_range(0, 999));
            cyc(rr < 4, (rr >= 4 && rr < 12),
                $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
